dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the data-memory request interface driven by the MEM stage.
//  Accepts one load/store request at a time over a valid/ready handshake and owns a word-organised RAM.
//  Applies byte-lane write enables.
//  Returns a response after a fixed, configurable latency, holding it until the requester accepts.
//  Lets the pipeline model slow or multi-cycle data memory in place of a combinational single-cycle array.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; power of two, >= 2
//  LATENCY  2    edges from request accept to rsp_valid high; legal range 1..15
//  AW       $clog2(DEPTH)  local, word-index width (not overridable)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active-low
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; high only in IDLE
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address; word index = req_addr[AW+1:2], bits [1:0] ignored
//  req_be     in   4   store byte enables, bit i -> bits [8i+7:8i]; ignored for loads
//  req_wdata  in   32  store data, lane-aligned
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester accepts response
//  rsp_rdata  out  32  load data; 0 for stores and errors
//  rsp_err    out  1   address out of range (req_addr[31:AW+2] != 0)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; counter=0.
//   - RAM contents are NOT cleared.
//  Accept: req_valid & req_ready sampled high at a rising edge (edge T0).
//   - Request fields are sampled only at this edge; changes to them outside accept are ignored.
//  At T0:
//   - Store in range: RAM word is written on byte lanes with req_be=1; other lanes keep their value.
//     be=4'b0000 writes nothing but still completes normally.
//   - Load in range: the addressed word is captured into the response data register.
//   - Out of range: no RAM access; err=1, rdata=0.
//  FSM:
//   - IDLE: on accept, go to RESP if LATENCY==1; otherwise go to WAIT with cnt=LATENCY-2.
//   - WAIT: if cnt==0 go to RESP, else decrement cnt. req_ready=0.
//   - RESP: rsp_valid=1; rsp_rdata and rsp_err held stable. req_ready=0.
//     If rsp_ready is high at an edge, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
//  Timing and throughput:
//   - rsp_valid rises exactly LATENCY edges after T0.
//   - No accept is possible in the cycle a response is consumed (req_ready is low in RESP).
//   - Minimum spacing between accepts is LATENCY+1 cycles.
//   - One transaction outstanding, so there is no read/write hazard inside the block.
//  Backpressure: rsp_ready low in RESP holds all response outputs indefinitely; no timeout.
//  req_valid while busy: ignored; the requester must hold it until req_ready=1.
//   - The block never drops an accepted request.
//  Reset mid-operation:
//   - Any pending response is discarded and outputs return to reset values.
//   - A store accepted before reset remains written.
//  rsp_ready while not in RESP: ignored.
// TESTING
//  1. Reset with LATENCY=2, DEPTH=256:
//     req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 during and after reset.
//  2. Store addr=0x10, be=4'hF, wdata=0xDEADBEEF at T0, rsp_ready=1:
//     rsp_valid high at T0+2 for one cycle, rdata=0, err=0.
//     Then load addr=0x10 -> rdata=0xDEADBEEF.
//  3. Store addr=0x10, be=4'b0101, wdata=0x11223344 over 0xDEADBEEF:
//     a subsequent load returns 0xDE22BE44.
//  4. Load addr=0x400 (out of range for DEPTH=256): rsp_err=1, rdata=0.
//     A follow-up load of addr=0x0 confirms word 0 is unchanged.
//  5. Backpressure: load completes with rsp_ready=0 for 5 cycles.
//     rsp_valid and rdata stay stable and req_ready stays 0; a new req_valid is not accepted.
//     Raising rsp_ready returns to IDLE on the next edge.
//  6. LATENCY=1 build: load accepted at T0 gives rsp_valid at T0+1.
//     Asserting rst_n=0 in WAIT (LATENCY=4) clears rsp_valid at once.
//     A store accepted before that reset is still readable afterwards.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, word-organised RAM with byte-lane
// writes, response after a fixed LATENCY and held until the requester takes it.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          oor;
  logic [AW-1:0] idx;
  logic          unused_addr_lsb;

  assign idx             = req_addr[AW+1:2];
  assign oor             = |req_addr[31:AW+2];
  assign accept          = req_valid && (state_q == IDLE);
  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        rdata_d = (req_we || oor) ? 32'd0 : mem[idx];
        err_d   = oor;
        if (LATENCY == 1) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM has no reset so a store accepted before a reset survives it.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_we && !oor) begin
      for (int b = 0; b < 4; b++)
        if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: three builds (LATENCY 2, 1, 4) checked against a
// transaction-level memory model.
module tb_dmem_responder;
  localparam int ND = 3;
  localparam int LAT[ND] = '{2, 1, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid [ND];
  logic        req_ready [ND];
  logic        req_we    [ND];
  logic [31:0] req_addr  [ND];
  logic [3:0]  req_be    [ND];
  logic [31:0] req_wdata [ND];
  logic        rsp_valid [ND];
  logic        rsp_ready [ND];
  logic [31:0] rsp_rdata [ND];
  logic        rsp_err   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_responder #(.DEPTH(256), .LATENCY(LAT[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_be   (req_be[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] mdl [ND][256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int d);
    chk({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata[d], 32'd0);
    chk({tag, "_err"},   32'(rsp_err[d]), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int d, input bit we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] er, output logic ee,
                       output bit ok);
    int n;
    logic [7:0] wi;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_be[d] = be; req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    ok = req_ready[d];
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    ee = (addr[31:10] != 22'd0);
    wi = addr[9:2];
    er = (we || ee) ? 32'd0 : mdl[d][wi];
    if (we && !ee)
      for (int b = 0; b < 4; b++) if (be[b]) mdl[d][wi][8*b +: 8] = wd[8*b +: 8];
    @(negedge clk);
    // fields after accept must not matter
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
    req_be[d] = 4'($urandom); req_wdata[d] = $urandom;
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input int hold, output logic [31:0] got);
    logic [31:0] er;
    logic ee;
    bit ok;
    int edges;
    got = 32'hx;
    issue(d, we, addr, be, wd, er, ee, ok);
    if (!ok) return;
    rsp_ready[d] = (hold > 0) ? 1'b0 : 1'($urandom);
    edges = 1;
    while (!rsp_valid[d] && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
    chk("latency", 32'(edges), 32'(LAT[d]));
    chk("rdata", rsp_rdata[d], er);
    chk("err", 32'(rsp_err[d]), 32'(ee));
    chk("ready_busy", 32'(req_ready[d]), 32'd0);
    got = rsp_rdata[d];
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_be[d] = 4'hF;
      req_addr[d] = {24'd0, 3'($urandom), 5'($urandom)} & 32'h7C;
      req_wdata[d] = $urandom;
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], er);
      chk("hold_err", 32'(rsp_err[d]), 32'(ee));
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_idle("consumed", d);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin : main
    logic [31:0] got, er, addr;
    logic ee;
    bit ok;
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_be[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) chk_idle("in_reset", d);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) chk_idle("after_reset", d);

    // give the model a known image of words 0..31
    for (int d = 0; d < ND; d++)
      for (int w = 0; w < 32; w++) txn(d, 1'b1, 32'(w * 4), 4'hF, $urandom, 0, got);

    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, got);
    chk("store_rdata0", got, 32'd0);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, got);
    chk("load_full", got, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h12, 4'b0101, 32'h11223344, 0, got);
    txn(0, 1'b0, 32'h13, 4'hF, 32'hFFFFFFFF, 0, got);
    chk("load_partial", got, 32'hDE22BE44);
    txn(0, 1'b1, 32'h10, 4'b0000, 32'h55555555, 0, got);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, got);
    chk("be_zero", got, 32'hDE22BE44);
    txn(0, 1'b0, 32'h400, 4'h0, 32'h0, 0, got);
    txn(0, 1'b1, 32'h400, 4'hF, 32'h12345678, 0, got);
    txn(0, 1'b0, 32'h0, 4'h0, 32'h0, 0, got);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 5, got);
    chk("backpressure", got, 32'hDE22BE44);
    txn(1, 1'b0, 32'h8, 4'h0, 32'h0, 0, got);

    for (int i = 0; i < 150; i++) begin
      int d;
      d = $urandom_range(0, ND - 1);
      addr = {24'd0, 1'b0, 5'($urandom), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) begin
        addr = $urandom;
        if (addr[31:10] == 22'd0) addr[31] = 1'b1;
      end
      txn(d, 1'($urandom), addr, 4'($urandom), $urandom, $urandom_range(0, 3), got);
    end

    // reset while waiting: pending store already landed in RAM
    issue(2, 1'b1, 32'h1C, 4'hF, 32'hCAFEF00D, er, ee, ok);
    chk("wait_state", 32'(rsp_valid[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_wait", 2);
    @(negedge clk);
    rst_n = 1'b1;
    // reset while a response is being held
    issue(2, 1'b0, 32'h24, 4'h0, 32'h0, er, ee, ok);
    n = 0;
    while (!rsp_valid[2] && n < 20) begin @(negedge clk); n++; end
    chk("resp_reached", 32'(rsp_valid[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_resp", 2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst", 2);
    txn(2, 1'b0, 32'h1C, 4'h0, 32'h0, 0, got);
    chk("store_survives", got, 32'hCAFEF00D);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
